// File: rtl/apb_pkg.sv
// Shared definitions for the APB register bank: FSM encoding, pprot bit indices, counter width.
package apb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StAccess
   } apb_state_e;

   localparam int unsigned PPROT_PRIV  = 0;
   localparam int unsigned PPROT_NSEC  = 1;
   localparam int unsigned PPROT_INSTR = 2;

   localparam int unsigned WS_W = 4;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_regbank_ws_if.sv
// APB3 bus signals for the register bank, with master and slave views.
interface apb_regbank_ws_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [2:0]            pprot;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_regbank_decode.sv
// Setup-phase address decode: register index and the combined error flag.
module apb_regbank_decode
   import apb_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          NUM_REGS  = 8,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
   parameter bit                   PRIV_ONLY = 1'b0,
   localparam int unsigned         LSB       = clog2(DATA_W / 8),
   localparam int unsigned         IDX_W     = clog2(NUM_REGS)
) (
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic              pwrite_i,
   input  logic              priv_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              err_o
);

   logic miss;
   logic misaligned;
   logic ro_write;
   logic unpriv;

   assign idx_o    = paddr_i[LSB+IDX_W-1:LSB];
   assign miss     = paddr_i[ADDR_W-1:LSB+IDX_W] != BASE_ADDR[ADDR_W-1:LSB+IDX_W];
   assign ro_write = pwrite_i && RO_MASK[idx_o];
   assign unpriv   = PRIV_ONLY && !priv_i;

   // Byte-wide registers have no sub-word address bits to check.
   if (LSB > 0) begin : g_align
      assign misaligned = |paddr_i[LSB-1:0];
   end else begin : g_no_align
      assign misaligned = 1'b0;
   end

   assign err_o = miss | misaligned | ro_write | unpriv;

endmodule

// File: rtl/apb_regbank_ws.sv
// Parametrised APB3 register bank with wait states, RO status mapping and access checking.
module apb_regbank_ws
   import apb_pkg::*;
#(
   parameter logic [31:0]          BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned          ADDR_W      = 32,
   parameter int unsigned          DATA_W      = 32,
   parameter int unsigned          NUM_REGS    = 8,
   parameter int unsigned          WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
   parameter bit                   PRIV_ONLY   = 1'b0
) (
   input  logic                         pclk,
   input  logic                         presetn,
   apb_regbank_ws_if.slave              bus,
   input  logic [NUM_REGS*DATA_W-1:0]   status_i,
   output logic [NUM_REGS*DATA_W-1:0]   reg_o
);

   localparam int unsigned IDX_W = clog2(NUM_REGS);
   localparam int unsigned NB    = DATA_W / 8;
   localparam logic [ADDR_W-1:0] BaseA = ADDR_W'(BASE_ADDR);

   apb_state_e          state_q, state_d;
   logic [WS_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   logic [IDX_W-1:0]    dec_idx;
   logic                dec_err;
   logic                ready;
   logic [DATA_W-1:0]   value;

   apb_regbank_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BaseA),
      .RO_MASK   (RO_MASK),
      .PRIV_ONLY (PRIV_ONLY)
   ) u_decode (
      .paddr_i  (bus.paddr),
      .pwrite_i (bus.pwrite),
      .priv_i   (bus.pprot[PPROT_PRIV]),
      .idx_o    (dec_idx),
      .err_o    (dec_err)
   );

   // Response is decoded from registered state only.
   assign ready       = (state_q == StAccess) && (cnt_q == '0);
   assign bus.pready  = ready;
   assign bus.pslverr = ready && err_q;
   assign bus.prdata  = (ready && !write_q && !err_q) ? value : '0;

   always_comb begin
      value = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            value = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W] : regs_q[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_o[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      err_d   = err_q;
      regs_d  = regs_q;
      unique case (state_q)
         StIdle: begin
            if (bus.psel && !bus.penable) begin
               state_d = StAccess;
               idx_d   = dec_idx;
               write_d = bus.pwrite;
               err_d   = dec_err;
               cnt_d   = WS_W'(WAIT_STATES);
            end
         end
         StAccess: begin
            if (!bus.psel) begin
               state_d = StIdle;
            end else if (bus.penable) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  state_d = StIdle;
                  if (write_q && !err_q) begin
                     for (int b = 0; b < NB; b++) begin
                        if (bus.pstrb[b]) regs_d[idx_q][b*8 +: 8] = bus.pwdata[b*8 +: 8];
                     end
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         err_q   <= err_d;
         regs_q  <= regs_d;
      end
   end

endmodule

// File: tb/tb_apb_regbank_ws.sv
// Scoreboard bench for apb_regbank_ws: two instances (2 and 0 wait states) against a register model.
module tb_apb_regbank_ws;

   localparam int unsigned NR = 8;
   localparam int unsigned DW = 32;
   localparam logic [31:0] BASE = 32'h4000_0000;

   typedef struct {
      int          lat;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstna, rstnb;
   logic [NR*DW-1:0]  stata, statb, rego_a, rego_b;

   apb_regbank_ws_if #(.ADDR_W(32), .DATA_W(DW)) busa ();
   apb_regbank_ws_if #(.ADDR_W(32), .DATA_W(DW)) busb ();

   apb_regbank_ws #(
      .BASE_ADDR (BASE), .ADDR_W (32), .DATA_W (DW), .NUM_REGS (NR),
      .WAIT_STATES (2), .RO_MASK (8'h80), .PRIV_ONLY (1'b1)
   ) dut_a (
      .pclk (clk), .presetn (rstna), .bus (busa), .status_i (stata), .reg_o (rego_a)
   );

   apb_regbank_ws #(
      .BASE_ADDR (BASE), .ADDR_W (32), .DATA_W (DW), .NUM_REGS (NR),
      .WAIT_STATES (0), .RO_MASK (8'h80), .PRIV_ONLY (1'b1)
   ) dut_b (
      .pclk (clk), .presetn (rstnb), .bus (busb), .status_i (statb), .reg_o (rego_b)
   );

   int          checks = 0;
   int          failures = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   int          acc [2];
   logic [31:0] model [2][NR];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int ws(input int w);
      return (w == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] stat(input int w, input int i);
      logic [NR*DW-1:0] s;
      s = (w == 0) ? stata : statb;
      return s[i*DW +: DW];
   endfunction

   // Access rules stated directly: window, word alignment, RO register 7, privilege.
   function automatic logic model_err(input logic wr, input logic [31:0] a, input logic [2:0] p);
      logic miss, mis, ro, unpriv;
      miss   = (a - (a % (NR * 4))) != BASE;
      mis    = (a % 4) != 0;
      ro     = wr && (((a / 4) % NR) == NR - 1);
      unpriv = (p % 2) == 0;
      return miss || mis || ro || unpriv;
   endfunction

   task automatic mon(input int w, input logic rstn, input logic sel, input logic en,
                      input logic rdy, input logic slverr, input logic [31:0] rd);
      exp_t e;
      logic got;
      if (!rstn) begin
         acc[w] = 0;
      end else if (sel && en) begin
         acc[w]++;
         if (rdy) begin
            got = 1'b0;
            if (w == 0) begin
               if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
            end else begin
               if (qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
            end
            check("resp_expected", got, 1);
            if (got) begin
               check("latency", acc[w], e.lat);
               check("pslverr", slverr, e.err);
               check("prdata", rd, e.rdata);
            end
            acc[w] = 0;
         end
      end else begin
         acc[w] = 0;
         check("no_resp_outside_access", {rdy, slverr}, 0);
      end
   endtask

   always @(negedge clk) mon(0, rstna, busa.psel, busa.penable, busa.pready, busa.pslverr,
                             busa.prdata);
   always @(negedge clk) mon(1, rstnb, busb.psel, busb.penable, busb.pready, busb.pslverr,
                             busb.prdata);

   task automatic drive(input int w, input logic sel, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p);
      if (w == 0) begin
         busa.psel = sel; busa.penable = en; busa.pwrite = wr; busa.paddr = a;
         busa.pwdata = d; busa.pstrb = s; busa.pprot = p;
      end else begin
         busb.psel = sel; busb.penable = en; busb.pwrite = wr; busb.paddr = a;
         busb.pwdata = d; busb.pstrb = s; busb.pprot = p;
      end
   endtask

   task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
      exp_t e;
      int   idx;
      logic err, done;
      idx     = int'((a / 4) % NR);
      err     = model_err(wr, a, p);
      e.lat   = ws(w) + 1;
      e.err   = err;
      e.rdata = (!wr && !err) ? ((idx == NR - 1) ? stat(w, idx) : model[w][idx]) : 32'h0;
      if (w == 0) qa.push_back(e);
      else qb.push_back(e);
      @(posedge clk); #1 drive(w, 1'b1, 1'b0, wr, a, d, s, p);
      @(posedge clk); #1 drive(w, 1'b1, 1'b1, wr, a, d, s, p);
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         done = (w == 0) ? busa.pready : busb.pready;
      end
      if (!done) check("pready_timeout", 0, 1);
      if (wr && !err) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[w][idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic check_regs(input int w);
      logic [NR*DW-1:0] r;
      r = (w == 0) ? rego_a : rego_b;
      for (int i = 0; i < NR; i++) begin
         check("reg_o", r[i*DW +: DW], (i == NR - 1) ? 32'h0 : model[w][i]);
      end
   endtask

   task automatic idle(input int w);
      @(posedge clk); #1 drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      check_regs(w);
   endtask

   task automatic rand_status(input int w);
      for (int i = 0; i < NR; i++) begin
         if (w == 0) stata[i*DW +: DW] = $urandom;
         else statb[i*DW +: DW] = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      logic [2:0]  p;
      acc[0] = 0; acc[1] = 0;
      for (int w = 0; w < 2; w++) for (int i = 0; i < NR; i++) model[w][i] = 32'h0;
      rstna = 1'b0; rstnb = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
      rand_status(0); rand_status(1);
      repeat (2) @(negedge clk);
      check("reset_pready", {busa.pready, busb.pready}, 0);
      check("reset_pslverr", {busa.pslverr, busb.pslverr}, 0);
      check("reset_prdata", {busa.prdata, busb.prdata}, 0);
      check_regs(0); check_regs(1);
      @(posedge clk); #1 rstna = 1'b1; rstnb = 1'b1;

      // Full and partial-strobe writes.
      xfer(0, 1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 3'b001);
      idle(0);
      check("write_full", rego_a[63:32], 32'hDEAD_BEEF);
      xfer(0, 1'b1, 32'h4000_0004, 32'h1122_3344, 4'b0101, 3'b001);
      xfer(0, 1'b0, 32'h4000_0004, 32'h0, 4'h0, 3'b001);
      idle(0);
      check("write_strobed", rego_a[63:32], 32'hDE22_BE44);

      // RO status register read, then rejected write.
      stata[7*DW +: DW] = 32'hCAFE_0001;
      xfer(0, 1'b0, 32'h4000_001C, 32'h0, 4'h0, 3'b001);
      xfer(0, 1'b1, 32'h4000_001C, 32'h1234_5678, 4'hF, 3'b001);
      xfer(0, 1'b0, 32'h4000_001C, 32'h0, 4'h0, 3'b001);

      // Error cases: window miss, misaligned, unprivileged.
      xfer(0, 1'b0, 32'h5000_0000, 32'h0, 4'h0, 3'b001);
      xfer(0, 1'b0, 32'h4000_0006, 32'h0, 4'h0, 3'b001);
      xfer(0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 3'b000);
      idle(0);

      // Back-to-back write/read, then an aborted write.
      xfer(0, 1'b1, 32'h4000_0008, 32'hA5A5_1234, 4'hF, 3'b001);
      xfer(0, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 3'b001);
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, 1'b1, 32'h4000_0008, 32'h0BAD_0BAD, 4'hF, 3'b001);
      @(posedge clk); #1 drive(0, 1'b1, 1'b1, 1'b1, 32'h4000_0008, 32'h0BAD_0BAD, 4'hF, 3'b001);
      @(posedge clk); #1 drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001);
      idle(0);
      xfer(0, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 3'b001);
      idle(0);

      // Reset during the second wait cycle of a write.
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, 1'b1, 32'h4000_000C, 32'h7777_7777, 4'hF, 3'b001);
      @(posedge clk); #1 drive(0, 1'b1, 1'b1, 1'b1, 32'h4000_000C, 32'h7777_7777, 4'hF, 3'b001);
      @(posedge clk); #1 rstna = 1'b0;
      for (int i = 0; i < NR; i++) model[0][i] = 32'h0;
      @(negedge clk);
      check("midreset_pready", busa.pready, 0);
      check_regs(0);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
      @(posedge clk); #1 rstna = 1'b1;
      xfer(0, 1'b0, 32'h4000_000C, 32'h0, 4'h0, 3'b001);
      idle(0);

      // Zero wait states: same basic sequence on the second instance.
      xfer(1, 1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 3'b001);
      xfer(1, 1'b1, 32'h4000_0004, 32'h1122_3344, 4'b0101, 3'b001);
      xfer(1, 1'b0, 32'h4000_0004, 32'h0, 4'h0, 3'b001);
      xfer(1, 1'b0, 32'h4000_001C, 32'h0, 4'h0, 3'b001);
      xfer(1, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 3'b000);
      idle(1);
      check("ws0_write_strobed", rego_b[63:32], 32'hDE22_BE44);

      // Randomized traffic on both instances.
      for (int w = 0; w < 2; w++) begin
         for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = BASE + $urandom_range(0, NR * 4 - 1);
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            d = $urandom;
            p = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b001;
            xfer(w, 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), p);
            if ($urandom_range(0, 3) == 0) begin
               idle(w);
               rand_status(w);
            end
         end
         idle(w);
      end

      repeat (2) @(negedge clk);
      check("queue_a_drained", qa.size(), 0);
      check("queue_b_drained", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
